// File: rtl/fifo_push_arbiter_pkg.sv
// Shared types and helpers for the round-robin FIFO push arbiter.
// The optional burst feature is enabled with the FIFO_ARB_BURST_EN macro.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

    // Distance walked upward from start to reach pos, wrapping modulo n.
    function automatic int rr_distance(input int pos, input int start, input int n);
        return (pos + n - start) % n;
    endfunction

endpackage

// File: rtl/fifo_push_arbiter_if.sv
// Producer/FIFO-facing bundle of the push arbiter.
// slave is the arbiter side; master is the producers plus fifo_top.full_o.
interface fifo_push_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]            req_i;
    logic [N_REQ-1:0][WIDTH-1:0] data_i;
    logic                        fifo_full_i;
    logic [N_REQ-1:0]            gnt_o;
    logic [N_REQ-1:0]            ack_o;
    logic                        fifo_push_o;
    logic [WIDTH-1:0]            fifo_data_o;
    logic                        busy_o;

    modport master (
        output req_i, data_i, fifo_full_i,
        input  gnt_o, ack_o, fifo_push_o, fifo_data_o, busy_o
    );

    modport slave (
        input  req_i, data_i, fifo_full_i,
        output gnt_o, ack_o, fifo_push_o, fifo_data_o, busy_o
    );
endinterface

// File: rtl/fifo_push_arbiter_rr_pick.sv
// Combinational round-robin picker: first unmasked request at or above start,
// wrapping around; valid is low when nothing is eligible.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = clog2_min1(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] start,
    input  logic [N_REQ-1:0] mask,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [N_REQ-1:0] cand;
    int               best;

    assign cand = req & ~mask;

    always_comb begin
        // NOTE: every output is given a default before the search so no path infers a latch.
        idx   = '0;
        valid = 1'b0;
        best  = N_REQ;
        for (int p = 0; p < N_REQ; p++) begin
            if (cand[p] && (rr_distance(p, int'(start), N_REQ) < best)) begin
                best  = rr_distance(p, int'(start), N_REQ);
                idx   = IDX_W'(p);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin push arbiter sharing one fifo_top write port between N_REQ producers.
// Define FIFO_ARB_BURST_EN to hold a grant for up to MAX_BURST pushes; otherwise one push per grant.
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 4
) (
    input logic              clk_i,
    input logic              rst_i,
    fifo_push_arbiter_if.slave bus
);

    localparam int IDX_W = clog2_min1(N_REQ);

    if (N_REQ < 2 || MAX_BURST < 1) begin : g_bad_params
        $error("fifo_push_arbiter: need N_REQ >= 2 and MAX_BURST >= 1");
    end

    arb_state_e       state, state_nxt;
    logic [IDX_W-1:0] owner, owner_nxt;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [N_REQ-1:0] gnt_q;
    logic [IDX_W-1:0] owner_inc;
    logic [N_REQ-1:0] owner_mask;
    logic [IDX_W-1:0] pick_start, pick_idx;
    logic [N_REQ-1:0] pick_mask;
    logic             pick_valid;
    logic             push, burst_last, burst_exit, start_burst;

    assign owner_inc  = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + IDX_W'(1);
    assign owner_mask = N_REQ'(1) << owner;

    // Idle: search from rr_ptr. Burst: search past the owner, excluding it.
    assign pick_start = (state == ARB_BURST) ? owner_inc  : rr_ptr;
    assign pick_mask  = (state == ARB_BURST) ? owner_mask : '0;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req   (bus.req_i),
        .start (pick_start),
        .mask  (pick_mask),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Reset gating drops the in-flight word of a cycle in which reset is asserted.
    assign push = (state == ARB_BURST) && bus.req_i[owner] && !bus.fifo_full_i && rst_i;

`ifdef FIFO_ARB_BURST_EN
    localparam int CNT_W = clog2_min1(MAX_BURST + 1);
    logic [CNT_W-1:0] burst_cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_i)           burst_cnt <= '0;
        else if (start_burst) burst_cnt <= '0;
        else if (push)        burst_cnt <= burst_cnt + CNT_W'(1);
    end

    assign burst_last = push && (burst_cnt == CNT_W'(MAX_BURST - 1));
`else
    assign burst_last = push;
`endif

    assign burst_exit = (state == ARB_BURST) && (!bus.req_i[owner] || burst_last);

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        rr_ptr_nxt  = rr_ptr;
        start_burst = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_nxt   = ARB_BURST;
                    owner_nxt   = pick_idx;
                    start_burst = 1'b1;
                end
            end
            ARB_BURST: begin
                if (burst_exit) begin
                    rr_ptr_nxt = owner_inc;
                    if (pick_valid) begin
                        owner_nxt   = pick_idx;
                        start_burst = 1'b1;
                    end else begin
                        state_nxt = ARB_IDLE;
                    end
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_i) begin
            state  <= ARB_IDLE;
            owner  <= '0;
            rr_ptr <= '0;
            gnt_q  <= '0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            rr_ptr <= rr_ptr_nxt;
            gnt_q  <= (state_nxt == ARB_BURST) ? (N_REQ'(1) << owner_nxt) : '0;
        end
    end

    assign bus.gnt_o       = gnt_q;
    assign bus.busy_o      = (state == ARB_BURST);
    assign bus.ack_o       = push ? owner_mask : '0;
    assign bus.fifo_push_o = push;
    assign bus.fifo_data_o = push ? bus.data_i[owner] : '0;

endmodule

// File: doc/fifo_push_arbiter.md
# fifo_push_arbiter

Round-robin push arbiter that shares one `fifo_top` write port between `N_REQ` producers. It grants the FIFO to one requester at a time and holds that grant for a bounded burst of pushes. It stalls on `full_o` back-pressure and drives the FIFO's `push_i`/`data_i` pair. The block sits directly in front of `fifo_top`; the FIFO pop side is untouched.

## Interface
- `WIDTH`, 32: data word width; must match `fifo_top`.
- `N_REQ`, 4: number of producers; ≥2.
- `MAX_BURST`, 4: maximum pushes per grant; ≥1.
- `clk_i`  in  1  single clock, rising edge.
- `rst_i`  in  1  reset, synchronous, active-low.
- `req_i`  in  N_REQ  per-producer push request; the producer holds it while it has data.
- `data_i`  in  N_REQ×WIDTH  per-producer data word; stable while `req_i[k]` is high and not yet accepted.
- `fifo_full_i`  in  1  from `fifo_top.full_o`.
- `gnt_o`  out  N_REQ  registered one-hot owner; all zero when idle.
- `ack_o`  out  N_REQ  combinational, one-hot; a word from producer k is consumed this cycle.
- `fifo_push_o`  out  1  to `fifo_top.push_i`.
- `fifo_data_o`  out  WIDTH  to `fifo_top.data_i`.
- `busy_o`  out  1  high in BURST.

## Operation
- States: IDLE and BURST. Registers: `state`, `owner` (clog2(N_REQ) bits), `rr_ptr` (same width), `burst_cnt` (clog2(MAX_BURST+1) bits).
- Pick function: first set bit of `req_i` searching upward from `rr_ptr`, wrapping modulo N_REQ.
- IDLE:
  - `gnt_o`=0 and no push.
  - If `req_i`≠0: go to BURST with `owner`=pick and `burst_cnt`=0.
- BURST, owner k:
  - `gnt_o[k]`=1.
  - `ack_o[k]` = `fifo_push_o` = `req_i[k] & ~fifo_full_i`.
  - `fifo_data_o` = `data_i[k]`.
  - Each push increments `burst_cnt`.
- Burst exit occurs when either:
  - `req_i[k]`=0, or
  - a push occurs with `burst_cnt`==MAX_BURST-1.
- On exit:
  - `rr_ptr` becomes (k+1) mod N_REQ.
  - Pick over `req_i` with bit k masked, from (k+1) mod N_REQ.
  - If the pick is non-empty: stay in BURST with the new owner and `burst_cnt`=0. This is back-to-back with no idle cycle.
  - Otherwise go to IDLE.
- Full: while `fifo_full_i`=1, there is no push, no ack, and the counter holds. The owner keeps the grant indefinitely unless `req_i[k]` drops.
- Non-owner requests are never acked. `fifo_data_o` is 0 when there is no push.
- `fifo_push_o` is never asserted while `fifo_full_i`=1.

## Timing
- Reset (`rst_i`=0 at an edge):
  - `state`=IDLE, `owner`=0, `rr_ptr`=0, `burst_cnt`=0.
  - `gnt_o`=0 and `busy_o`=0.
  - `ack_o`, `fifo_push_o` and `fifo_data_o` are 0 in the following cycle.
  - Reset mid-burst drops the grant; the in-flight word that cycle is not pushed.
- Latency from IDLE: `req_i` high at cycle t gives `gnt_o` at t+1. The first push is at t+1 if the FIFO is not full.
- Throughput: 1 word per cycle inside a burst and across burst handovers.
- Simultaneous events: when the owner exit condition and other requests coincide, the handover happens on the same edge. A deasserting owner is not re-picked that cycle.

## Configuration
- `FIFO_ARB_BURST_EN` defined: behaviour is as above with `MAX_BURST`.
- `FIFO_ARB_BURST_EN` undefined:
  - `MAX_BURST` is ignored and treated as 1, so every push ends the grant.
  - Strict one-word round-robin applies.
  - `burst_cnt` is not instantiated.

## Structure
- Package `fifo_arb_pkg`:
  - `arb_state_e` enum (ARB_IDLE, ARB_BURST).
  - Function `clog2_min1` for pointer widths.
- Sub-module `rr_pick`: combinational round-robin priority picker. Inputs are a request vector, a start index and a mask. Outputs are an index and a `valid` flag.

## Test plan
- Single producer: `req_i`=0001 with data 0xA0..0xA5, burst on, MAX_BURST=4 → 4 pushes; then a handover to the same producer once alone (the re-pick falls to IDLE, then re-grants after 1 cycle); all 6 words in order.
- Four producers all requesting, burst off → grants in order 0,1,2,3,0 on consecutive cycles; `fifo_push_o` high every cycle.
- Full stall: owner 2 pushing and `fifo_full_i` high for 3 cycles → no push or ack during those cycles; `gnt_o`=0100 held; `burst_cnt` is unchanged and the burst resumes afterwards.
- Owner drops `req_i` after 2 words while producer 3 requests → handover on the same edge; `gnt_o` goes 0100→1000 with no idle cycle.
- Reset asserted mid-burst → the next cycle has all outputs 0, `rr_ptr`=0, and no push.
- FIFO integration with `fifo_top` at DEPTH=4: 3 producers each send 4 words → no `fifo_push_o` while full, and the pop order matches the grant order.
